// File: rtl/set_pkg.sv
// Shared definitions for the clock setting front-end.
//   mode_t          : setting-path state, also the encoding shown on the display
//   DEF_DEB_CYCLES  : default debounce stability window in clk cycles
//   DEF_TIMEOUT_S   : default idle timeout in seconds (0 disables it)
package set_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_CLK = 2'd1,
    SET_ALM = 2'd2,
    SET_CAL = 2'd3
  } mode_t;

  localparam int DEF_DEB_CYCLES = 20000;
  localparam int DEF_TIMEOUT_S  = 10;

endpackage

// File: rtl/set_mode_ctrl_key_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, stability counter
// and registered press pulse on the debounced rising edge.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   raw   : asynchronous active-high key input
//   level : debounced key level
//   press : one-clk pulse when the debounced level rises
module key_debounce
  import set_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      // stage p0/p1: metastability filter on the raw key
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stability stage: the level only follows after DEB_CYCLES+1
      // consecutive mismatching samples; any agreement restarts the count
      press <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync_p1;
        press <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/set_mode_ctrl.sv
// Setting-path front-end: debounces the four keys, steps the
// RUN / SET_CLK / SET_ALM / SET_CAL state machine on mode presses, drops
// back to RUN after an idle timeout, and forwards Less/Middle/Big presses
// to the set-routing mux while a SET state is active.
//   clk, rst         : system clock, synchronous active-high reset
//   tick_1hz         : one-clk pulse per second
//   *_btn            : raw asynchronous keys, active-high
//   set_clock/alarm/calendar : one-hot select of the target being set
//   Less/Middle/Big  : one-clk press pulses, SET states only
//   mode             : encoded state for display (0 RUN .. 3 CAL)
module set_mode_ctrl
  import set_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int TIMEOUT_S  = DEF_TIMEOUT_S
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       less_btn,
  input  logic       middle_btn,
  input  logic       big_btn,
  output logic       set_clock,
  output logic       set_alarm,
  output logic       set_calendar,
  output logic       Less,
  output logic       Middle,
  output logic       Big,
  output logic [1:0] mode
);

  localparam int IDLE_W = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_S);
  localparam bit TIMEOUT_EN = (TIMEOUT_S > 0);

  logic mode_press, less_press, middle_press, big_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk(clk), .rst(rst), .raw(mode_btn), .level(), .press(mode_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_less_deb (
    .clk(clk), .rst(rst), .raw(less_btn), .level(), .press(less_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_middle_deb (
    .clk(clk), .rst(rst), .raw(middle_btn), .level(), .press(middle_press)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_big_deb (
    .clk(clk), .rst(rst), .raw(big_btn), .level(), .press(big_press)
  );

  mode_t             state;
  mode_t             state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;
  logic              state_chg;
  logic              any_press;

  // A mode press takes priority over the timeout; from SET_CAL both lead
  // to RUN, so a coincidence can never advance twice.
  always_comb begin
    any_press = mode_press | less_press | middle_press | big_press;
    timeout   = TIMEOUT_EN && (state != RUN) && (idle_cnt == IDLE_MAX);
    state_nxt = state;
    if (mode_press) begin
      case (state)
        RUN:     state_nxt = SET_CLK;
        SET_CLK: state_nxt = SET_ALM;
        SET_ALM: state_nxt = SET_CAL;
        default: state_nxt = RUN;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end
    state_chg = (state_nxt != state);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      idle_cnt     <= '0;
      set_clock    <= 1'b0;
      set_alarm    <= 1'b0;
      set_calendar <= 1'b0;
      mode         <= 2'd0;
      Less         <= 1'b0;
      Middle       <= 1'b0;
      Big          <= 1'b0;
    end else begin
      // stage p0: state and idle timer; activity clears before a tick counts
      state <= state_nxt;
      if ((state == RUN) || state_chg || any_press) begin
        idle_cnt <= '0;
      end else if (tick_1hz && (idle_cnt != IDLE_MAX)) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      // stage p1: registered decode of the current state
      set_clock    <= (state == SET_CLK);
      set_alarm    <= (state == SET_ALM);
      set_calendar <= (state == SET_CAL);
      mode         <= state;
      // key pulses are dropped in RUN and in any cycle that leaves a state
      Less   <= less_press   && (state != RUN) && !state_chg;
      Middle <= middle_press && (state != RUN) && !state_chg;
      Big    <= big_press    && (state != RUN) && !state_chg;
    end
  end

endmodule

// File: tb/tb_set_mode_ctrl.sv
module tb_set_mode_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       mode_btn = 1'b0, less_btn = 1'b0, middle_btn = 1'b0, big_btn = 1'b0;
  logic       set_clock, set_alarm, set_calendar, Less, Middle, Big;
  logic [1:0] mode;

  always #5 clk = ~clk;

  set_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .mode_btn(mode_btn), .less_btn(less_btn), .middle_btn(middle_btn), .big_btn(big_btn),
    .set_clock(set_clock), .set_alarm(set_alarm), .set_calendar(set_calendar),
    .Less(Less), .Middle(Middle), .Big(Big), .mode(mode)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A key's debounced level flips once the raw key, seen two samples late,
  // has held the opposite value for DEB+1 consecutive samples. The mode
  // logic is a plain integer state 0..3 with an unbounded idle-second count.
  logic [DEB+2:0] hist [4];
  logic           lvl  [4];
  logic [3:0]     pprev;
  int             st, idle;
  logic [7:0]     m_out;
  bit             mdl_on = 1'b0;

  always @(posedge clk) begin : ref_model
    logic [3:0] raw, pnew;
    logic [DEB:0] win;
    int nst;
    bit chg, tmo;
    raw = {big_btn, middle_btn, less_btn, mode_btn};
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        hist[k] = '0;
        lvl[k]  = 1'b0;
      end
      pprev = '0; st = 0; idle = 0; m_out = '0;
    end else begin
      tmo = (TO > 0) && (st != 0) && (idle >= TO);
      if (pprev[0])  nst = (st + 1) % 4;
      else if (tmo)  nst = 0;
      else           nst = st;
      chg = (nst != st);
      m_out[7:6] = 2'(st);
      m_out[5]   = (st == 1);
      m_out[4]   = (st == 2);
      m_out[3]   = (st == 3);
      m_out[2]   = pprev[1] && (st != 0) && !chg;
      m_out[1]   = pprev[2] && (st != 0) && !chg;
      m_out[0]   = pprev[3] && (st != 0) && !chg;
      if ((st == 0) || chg || (pprev != 4'b0)) idle = 0;
      else if (tick_1hz) idle++;
      st = nst;
      for (int k = 0; k < 4; k++) begin
        hist[k] = {hist[k][DEB+1:0], raw[k]};
        win     = hist[k][DEB+2:2];
        pnew[k] = 1'b0;
        if ((!lvl[k] && (&win)) || (lvl[k] && !(|win))) begin
          lvl[k]  = ~lvl[k];
          pnew[k] = lvl[k];
        end
      end
      pprev = pnew;
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      n_chk++;
      if ({mode, set_clock, set_alarm, set_calendar, Less, Middle, Big} !== m_out) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: got %b, expected %b", $time,
                 {mode, set_clock, set_alarm, set_calendar, Less, Middle, Big}, m_out);
      end
    end
  end

  // pulse-cycle counters, sampled on the inactive edge
  int c_l = 0, c_m = 0, c_b = 0;
  always @(negedge clk) begin
    if (Less)   c_l++;
    if (Middle) c_m++;
    if (Big)    c_b++;
  end

  task automatic drive_keys(input logic [3:0] k);
    {big_btn, middle_btn, less_btn, mode_btn} = k;
  endtask

  task automatic run_press(input logic [3:0] keys, input int hold,
                           output int dl, output int dm, output int db);
    int l0, m0, b0;
    @(posedge clk); #1;
    l0 = c_l; m0 = c_m; b0 = c_b;
    @(negedge clk); drive_keys(keys);
    repeat (hold) @(negedge clk);
    drive_keys(4'b0);
    repeat (14) @(negedge clk);
    @(posedge clk); #1;
    dl = c_l - l0; dm = c_m - m0; db = c_b - b0;
  endtask

  task automatic do_tick();
    @(negedge clk); tick_1hz = 1'b1;
    @(negedge clk); tick_1hz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] keys;   // {big, middle, less, mode}
    int         hold;
    int         exp_mode;
    int         exp_l, exp_m, exp_b;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int dl, dm, db, l0;
    int rem [4];
    logic [3:0] rv;

    tbl[0]  = '{4'b0001, 8, 1, 0, 0, 0};
    tbl[1]  = '{4'b0100, 3, 1, 0, 0, 0};   // short glitch
    tbl[2]  = '{4'b0100, 8, 1, 0, 1, 0};
    tbl[3]  = '{4'b0100, 5, 1, 0, 1, 0};   // shortest accepted press
    tbl[4]  = '{4'b0100, 4, 1, 0, 0, 0};   // longest rejected glitch
    tbl[5]  = '{4'b0001, 8, 2, 0, 0, 0};
    tbl[6]  = '{4'b1000, 8, 2, 0, 0, 1};
    tbl[7]  = '{4'b1110, 8, 2, 1, 1, 1};   // simultaneous keys all forwarded
    tbl[8]  = '{4'b0001, 8, 3, 0, 0, 0};
    tbl[9]  = '{4'b0010, 8, 3, 1, 0, 0};
    tbl[10] = '{4'b0001, 8, 0, 0, 0, 0};
    tbl[11] = '{4'b0010, 8, 0, 0, 0, 0};   // RUN suppresses keys
    tbl[12] = '{4'b0001, 8, 1, 0, 0, 0};
    tbl[13] = '{4'b1001, 8, 2, 0, 0, 0};   // mode and big together
    tbl[14] = '{4'b0001, 8, 3, 0, 0, 0};
    tbl[15] = '{4'b0001, 8, 0, 0, 0, 0};

    // reset with less held through it
    @(negedge clk); rst = 1'b1; less_btn = 1'b1;
    @(negedge clk); mdl_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mode", mode, 0);
    check("rst_sel", {set_clock, set_alarm, set_calendar}, 0);
    check("rst_pulse", {Less, Middle, Big}, 0);
    @(posedge clk); #1; l0 = c_l;
    repeat (15) @(negedge clk);
    less_btn = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    check("rst_held_less", c_l - l0, 0);
    check("rst_held_mode", mode, 0);

    for (int i = 0; i < 16; i++) begin
      run_press(tbl[i].keys, tbl[i].hold, dl, dm, db);
      check($sformatf("tbl%0d_mode", i), mode, tbl[i].exp_mode);
      check($sformatf("tbl%0d_less", i), dl, tbl[i].exp_l);
      check($sformatf("tbl%0d_middle", i), dm, tbl[i].exp_m);
      check($sformatf("tbl%0d_big", i), db, tbl[i].exp_b);
    end

    // exact latency from raw rise to select change
    @(negedge clk); mode_btn = 1'b1;
    @(posedge clk);
    repeat (DEB + 3) @(posedge clk);
    #1 check("lat_before", mode, 0);
    @(posedge clk); #1;
    check("lat_after", mode, 1);
    check("lat_sel", {set_clock, set_alarm, set_calendar}, 3'b100);
    @(negedge clk); mode_btn = 1'b0;
    repeat (10) @(negedge clk);

    // plain timeout from SET_CAL
    run_press(4'b0001, 8, dl, dm, db);
    run_press(4'b0001, 8, dl, dm, db);
    check("to1_entry", mode, 3);
    do_tick(); do_tick();
    check("to1_two_ticks", mode, 3);
    do_tick();
    check("to1_expired", mode, 0);
    check("to1_sel", {set_clock, set_alarm, set_calendar}, 0);

    // a key press restarts the idle count
    run_press(4'b0001, 8, dl, dm, db);
    run_press(4'b0001, 8, dl, dm, db);
    run_press(4'b0001, 8, dl, dm, db);
    check("to2_entry", mode, 3);
    do_tick(); do_tick();
    run_press(4'b0010, 8, dl, dm, db);
    check("to2_less", dl, 1);
    do_tick(); do_tick();
    check("to2_held", mode, 3);
    do_tick();
    check("to2_expired", mode, 0);

    // timeout and mode press land in the same cycle
    run_press(4'b0001, 8, dl, dm, db);
    run_press(4'b0001, 8, dl, dm, db);
    run_press(4'b0001, 8, dl, dm, db);
    check("co_entry", mode, 3);
    do_tick(); do_tick();
    @(negedge clk); mode_btn = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk); tick_1hz = 1'b1;
    @(negedge clk); tick_1hz = 1'b0;
    repeat (6) @(negedge clk); mode_btn = 1'b0;
    repeat (20) @(negedge clk);
    check("co_single_advance", mode, 0);

    // randomized traffic against the reference model
    for (int k = 0; k < 4; k++) rem[k] = 0;
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (rem[k] == 0) begin
          rv[k]  = 1'($urandom_range(0, 1));
          rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(6, 20));
        end else begin
          rem[k]--;
        end
      end
      drive_keys(rv);
      tick_1hz = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    drive_keys(4'b0); tick_1hz = 1'b0; rst = 1'b0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/set_mode_ctrl.md
Name: set_mode_ctrl

Overview:
- Front-end controller for the clock's setting path.
- Debounces the four raw push-buttons (mode, less, middle, big) and runs the RUN / SET_CLK / SET_ALM / SET_CAL mode state machine.
- Drives the one-hot set_clock / set_alarm / set_calendar selects and single-cycle Less/Middle/Big pulses into the set-routing mux.
- Returns to RUN automatically after an idle timeout.

Parameters:
- DEB_CYCLES, 20000: consecutive stable clk cycles required before a debounced level changes (>=1).
- TIMEOUT_S, 10: idle seconds in any SET state before forcing RUN; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-clk pulse per second from the timebase
- mode_btn  in  1  raw mode key, active-high, asynchronous
- less_btn  in  1  raw Less key, active-high, asynchronous
- middle_btn  in  1  raw Middle key, active-high, asynchronous
- big_btn  in  1  raw Big key, active-high, asynchronous
- set_clock  out  1  high in SET_CLK
- set_alarm  out  1  high in SET_ALM
- set_calendar  out  1  high in SET_CAL
- Less  out  1  one-clk press pulse, SET states only
- Middle  out  1  one-clk press pulse, SET states only
- Big  out  1  one-clk press pulse, SET states only
- mode  out  2  encoded state for display: 0 RUN, 1 CLK, 2 ALM, 3 CAL

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <= RUN; all outputs 0.
  - Debounce synchronisers, counters and debounced levels cleared to 0.
  - Idle counter cleared.
  - Reset mid-press: a key still held at release of rst produces exactly one pulse once debounced.
- Debounce, per key, identical:
  - 2-flop synchroniser.
  - Counter runs while the sync output differs from the debounced level; it clears on any match.
  - When the counter reaches DEB_CYCLES, the debounced level takes the sync value and the counter clears.
  - Press pulse = debounced rising edge, registered.
  - Latency: raw rise first sampled at edge N gives the pulse high during the cycle after edge N+DEB_CYCLES+2, for exactly one cycle.
  - Glitches shorter than DEB_CYCLES cycles produce no pulse.
  - Release produces no pulse.
- State machine, evaluated on debounced pulses:
  - mode press: RUN->SET_CLK->SET_ALM->SET_CAL->RUN.
  - Timeout (TIMEOUT_S>0): from any SET state, when the idle counter reaches TIMEOUT_S, the next state is RUN.
- Idle counter:
  - Increments on tick_1hz in SET states.
  - Clears on any key press pulse (any of the four), on every state change, and in RUN.
  - Saturates at TIMEOUT_S.
  - Width $clog2(TIMEOUT_S+1), minimum 1.
  - Timeout and a mode press in the same cycle: the mode press wins (normal advance); the counter clears.
- Selects:
  - set_clock/set_alarm/set_calendar/mode are registered decodes of state, updated the cycle after the transition edge.
  - The three selects are never high together; all are 0 in RUN.
- Key pulses:
  - Less/Middle/Big are registered: a debounced pulse in a SET state appears one cycle later.
  - Suppressed in RUN.
  - Suppressed in any cycle where a mode pulse or timeout also causes a transition.
  - Simultaneous less/middle/big pulses are all forwarded, since the downstream mux handles each independently.
- tick_1hz coincident with a key press: the clear wins; the counter ends at 0.

Decomposition:
- Shared package set_pkg:
  - mode_t enum (RUN=2'd0, SET_CLK=2'd1, SET_ALM=2'd2, SET_CAL=2'd3).
  - Default DEB_CYCLES and TIMEOUT_S constants.
- Sub-module key_debounce (param DEB_CYCLES; ports clk, rst, raw, level, press), instantiated four times.
- FSM and idle timer live in the top.

Test Plan:
- Reset: rst high 3 cycles with all keys low -> mode=0, all selects and pulses 0; hold less_btn high through reset -> exactly one Less pulse? No: state is RUN, so Less stays 0 and no transition occurs.
- Mode cycling (DEB_CYCLES=4): four clean mode presses -> mode 1,2,3,0. set_clock, then set_alarm, then set_calendar each high alone; each change lands exactly DEB_CYCLES+3 cycles after raw rise plus one register cycle.
- Debounce: a 3-cycle glitch on middle_btn in SET_CLK (DEB_CYCLES=4) -> no Middle pulse. A 10-cycle bounce train ending in a steady high -> exactly one Middle pulse.
- Key gating: in SET_ALM, press big_btn -> one Big pulse of width 1. In RUN, press less_btn -> Less stays 0.
- Timeout (TIMEOUT_S=3): enter SET_CAL, then 3 tick_1hz pulses with no key -> mode=0 after the third tick. Repeat with a less press after tick 2 -> still SET_CAL after 3 more ticks minus one; RUN on the third tick after the press.
- Coincidence: a mode pulse and a big pulse debounce in the same cycle in SET_CLK -> mode goes to 2 and no Big pulse. A timeout tick and a mode pulse coincide in SET_CAL -> RUN exactly once, with no double advance.
